// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard path: scan-code bytes of interest
// and the frame receiver state encoding.
// Imported by ps2_rx and ps2_key_decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT  = 8'hE0;  // extended-key prefix
  localparam logic [7:0] SC_BRK  = 8'hF0;  // break (key release) prefix
  localparam logic [7:0] SC_UP   = 8'h75;  // Up arrow, only after SC_EXT
  localparam logic [7:0] SC_DOWN = 8'h72;  // Down arrow, only after SC_EXT
  localparam logic [7:0] SC_W    = 8'h1D;  // W key
  localparam logic [7:0] SC_S    = 8'h1B;  // S key

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises both pins, glitch-filters ps2_clk,
// detects falling edges and assembles start/8 data/odd parity/stop frames.
// Ports: clk, reset (sync, active high), ps2_clk/ps2_data (raw pins) in;
//        code (last good byte), code_valid (1-cycle), frame_err (1-cycle) out.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  logic          clk_meta_q, clk_meta_d;
  logic          clk_sync_q, clk_sync_d;
  logic          dat_meta_q, dat_meta_d;
  logic          dat_sync_q, dat_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_edge_q, fall_edge_d;
  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    code_q, code_d;
  logic          code_valid_q, code_valid_d;
  logic          frame_err_q, frame_err_d;

  // Input conditioning: 2-FF synchronisers, then a saturating filter on
  // ps2_clk that only flips after FILTER_LEN consecutive differing samples.
  always_comb begin
    clk_meta_d = ps2_clk;
    clk_sync_d = clk_meta_q;
    dat_meta_d = ps2_data;
    dat_sync_d = dat_meta_q;
    filt_d     = filt_q;
    fcnt_d     = '0;
    if (clk_sync_q != filt_q) begin
      if (fcnt_q == FILT_LAST) begin
        filt_d = clk_sync_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
    fall_edge_d = filt_q & ~filt_d;
  end

  // Receiver FSM with inter-edge timeout.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    // tmo_q holds cycles elapsed since the last edge (the edge cycle counts
    // as one), so the error pulse lands exactly TIMEOUT_CYC after the edge.
    if (state_q == RX_IDLE || fall_edge_q) begin
      tmo_d = TW'(1);
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      RX_IDLE: begin
        if (fall_edge_q) begin
          if (!dat_sync_q) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (fall_edge_q) begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = RX_PARITY;
          end
        end
      end
      RX_PARITY: begin
        if (fall_edge_q) begin
          par_d   = dat_sync_q;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall_edge_q) begin
          if (dat_sync_q && ((^shift_q) ^ par_q)) begin
            code_valid_d = 1'b1;
            code_d       = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    if (state_q != RX_IDLE && !fall_edge_q && tmo_q == TMO_LAST) begin
      frame_err_d = 1'b1;
      state_d     = RX_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q   <= 1'b1;
      clk_sync_q   <= 1'b1;
      dat_meta_q   <= 1'b1;
      dat_sync_q   <= 1'b1;
      filt_q       <= 1'b1;
      fcnt_q       <= '0;
      fall_edge_q  <= 1'b0;
      state_q      <= RX_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      code_q       <= 8'h00;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_meta_q   <= clk_meta_d;
      clk_sync_q   <= clk_sync_d;
      dat_meta_q   <= dat_meta_d;
      dat_sync_q   <= dat_sync_d;
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      fall_edge_q  <= fall_edge_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: frame receiver plus make/break/extended interpreter
// producing held-key levels (Up/W, Down/S) and the last plain make code.
// Ports: clk, reset, ps2_clk, ps2_data in; data_tx, up_key_press,
//        down_key_press, code_valid, code, frame_err out.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_tx,
  output logic       up_key_press,
  output logic       down_key_press,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       frame_err
);

  logic [7:0] rx_code;
  logic       rx_vld;
  logic       rx_err;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (rx_code),
    .code_valid(rx_vld),
    .frame_err (rx_err)
  );

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic [7:0] data_tx_q, data_tx_d;
  logic       is_up;
  logic       is_down;
  logic       make;

  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    up_d      = up_q;
    down_d    = down_q;
    data_tx_d = data_tx_q;
    // 75/72 are arrows only behind E0; bare they are keypad 8/2.
    is_up     = ext_q ? (rx_code == SC_UP)   : (rx_code == SC_W);
    is_down   = ext_q ? (rx_code == SC_DOWN) : (rx_code == SC_S);
    make      = ~brk_q;

    if (rx_err) begin
      // A lost byte may have been a prefix; start clean. Held levels stay.
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_vld) begin
      if (rx_code == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_code == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (is_up) begin
          up_d = make;
        end
        if (is_down) begin
          down_d = make;
        end
        if (make && !ext_q) begin
          data_tx_d = rx_code;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      data_tx_q <= 8'h00;
    end else begin
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      up_q      <= up_d;
      down_q    <= down_d;
      data_tx_q <= data_tx_d;
    end
  end

  assign data_tx        = data_tx_q;
  assign up_key_press   = up_q;
  assign down_key_press = down_q;
  assign code_valid     = rx_vld;
  assign code           = rx_code;
  assign frame_err      = rx_err;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Receives PS/2 keyboard frames and decodes make/break/extended scan codes into held-key levels for the game logic. It is the upstream stage feeding the game module's up_key_press, down_key_press and data_tx inputs, and sits directly behind the board's PS/2 pins. The block includes the raw frame receiver with synchronisation, glitch filtering, parity check and inter-edge timeout, plus the scan-code interpreter.

Parameters:
FILTER_LEN, 8, consecutive identical samples required before the filtered ps2_clk changes state.
TIMEOUT_CYC, 20000, clk cycles allowed between falling edges inside a frame (200 us at 100 MHz).

Ports:
clk  input  1  system clock, 100 MHz.
reset  input  1  synchronous, active-high reset.
ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
ps2_data  input  1  raw PS/2 data pin, asynchronous.
data_tx  output  8  last non-extended make code received, held until the next one.
up_key_press  output  1  level, high while Up-arrow (E0 75) or W (1D) is held.
down_key_press  output  1  level, high while Down-arrow (E0 72) or S (1B) is held.
code_valid  output  1  one-cycle pulse when any frame is received without error.
code  output  8  raw byte of the last good frame, valid with code_valid.
frame_err  output  1  one-cycle pulse on a bad start bit, parity error, stop error or timeout.

Behaviour:
- Reset: all outputs are 0. FSM goes to IDLE. The ext and brk flags are cleared. The filter is preset to 1 (bus idle high). Reset applies mid-frame with no residue.
- Input conditioning: both pins pass through 2-FF synchronisers. ps2_clk then passes through a FILTER_LEN saturating filter. fall_edge is a 1-cycle pulse on a filtered 1->0 transition. Data is sampled at fall_edge.
- Receiver FSM states are IDLE, DATA, PARITY, STOP.
  - IDLE: on fall_edge, if data=0 go to DATA with bit count 0. If data=1, pulse frame_err and stay in IDLE.
  - DATA: shift 8 bits in, LSB first. Go to PARITY after bit 7.
  - PARITY: the parity bit is captured. Odd parity is required: XOR of the 8 data bits and the parity bit must equal 1.
  - STOP: the stop bit must be 1. If stop and parity are good, pulse code_valid with code updated in the same cycle, one cycle after the stop fall_edge. Otherwise pulse frame_err. Either way return to IDLE.
- Timeout: in any state other than IDLE, a counter reloads on every fall_edge. If it reaches TIMEOUT_CYC, pulse frame_err and return to IDLE. The partial byte is discarded.
- Interpreter, acting on code_valid:
  - E0 sets ext.
  - F0 sets brk.
  - Any other byte is a key event with make = !brk, after which ext and brk are both cleared.
  - Key map: Up is E0 75 or non-ext 1D. Down is E0 72 or non-ext 1B. A make event sets the mapped level and a break event clears it.
  - Any non-ext make updates data_tx, including 1D and 1B.
  - Unmapped codes affect only data_tx.
- Level outputs and data_tx update one cycle after code_valid.
- Typematic repeats (repeated makes) leave a level at 1.
- Up and down held together: both levels are high; priority is resolved downstream.
- frame_err also clears ext and brk, so a following byte is interpreted as a fresh code. Held levels are not cleared by errors.
- 75 or 72 without the E0 prefix (keypad 8/2) is not Up/Down.
- A break code for a key that is not held is harmless; the level stays at 0.

Decomposition:
- Package ps2_pkg holds the constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_UP=8'h75, SC_DOWN=8'h72, SC_W=8'h1D, SC_S=8'h1B, and the receiver state enum.
- Sub-module ps2_rx contains the synchronisers, filter, edge detect, receiver FSM and timeout. It outputs code, code_valid and frame_err.
- The top level adds the interpreter.

Test Plan:
- Frame 0x1D with odd parity bit 1, edges every 5000 cycles -> code_valid=1 and code=1D. up_key_press=1 and data_tx=1D one cycle later.
- Sequence E0 75, then E0 F0 75 -> up_key_press rises after the first 75 and falls after the second. data_tx is unchanged throughout.
- Hold E0 72 and 1D, then F0 1D -> both levels high; afterwards up=0 and down stays 1.
- Frame 0x75 with a wrong parity bit, preceded by E0 -> frame_err pulse, no code_valid, ext cleared. A subsequent 75 alone leaves up_key_press=0.
- Stop after 4 data bits -> frame_err pulses exactly TIMEOUT_CYC cycles after the last edge. A following valid 1B frame then decodes correctly with down=1.
- 3-cycle glitch pulses on ps2_clk plus reset asserted mid-frame -> no edges from the glitches. After reset all outputs are 0 and the next full frame decodes normally.
